// File: rtl/ssm_pkg.sv
// ssm_pkg: shared constants for the FP16 SSM I/O sequencer.
// Holds the operand field layout of one input frame, the frame length
// helpers and the sequencer FSM state encoding.
package ssm_pkg;

  // Default block dimensions (batch, heads, head dim, state dim).
  localparam int DEF_B = 1;
  localparam int DEF_H = 4;
  localparam int DEF_P = 4;
  localparam int DEF_N = 4;

  typedef enum logic [2:0] {
    RST_IDLE = 3'd0,
    LOAD     = 3'd1,
    FIRE     = 3'd2,
    WAIT     = 3'd3,
    DRAIN    = 3'd4
  } seq_state_t;

  // Operand fields in the order they arrive on the input stream.
  typedef enum logic [2:0] {
    F_DT = 3'd0,
    F_DA = 3'd1,
    F_B  = 3'd2,
    F_C  = 3'd3,
    F_D  = 3'd4,
    F_X  = 3'd5,
    F_H  = 3'd6
  } field_t;

  // Number of words a field occupies in a frame.
  function automatic int field_size(input field_t f, input int b, input int h,
                                    input int p, input int n);
    case (f)
      F_DT, F_DA: return b * h;
      F_B, F_C:   return b * n;
      F_D:        return h;
      F_X:        return b * h * p;
      F_H:        return b * h * p * n;
      default:    return 0;
    endcase
  endfunction

  // Word index of the first word of a field within the frame.
  function automatic int field_off(input field_t f, input int b, input int h,
                                   input int p, input int n);
    case (f)
      F_DT:    return 0;
      F_DA:    return b * h;
      F_B:     return 2 * b * h;
      F_C:     return 2 * b * h + b * n;
      F_D:     return 2 * b * h + 2 * b * n;
      F_X:     return 2 * b * h + 2 * b * n + h;
      F_H:     return 2 * b * h + 2 * b * n + h + b * h * p;
      default: return 0;
    endcase
  endfunction

  // Input frame length in words.
  function automatic int w_in(input int b, input int h, input int p, input int n);
    return field_off(F_H, b, h, p, n) + field_size(F_H, b, h, p, n);
  endfunction

  // Output frame length in words.
  function automatic int w_out(input int b, input int h, input int p);
    return b * h * p;
  endfunction

  localparam int OFF_DT = field_off(F_DT, DEF_B, DEF_H, DEF_P, DEF_N);
  localparam int OFF_DA = field_off(F_DA, DEF_B, DEF_H, DEF_P, DEF_N);
  localparam int OFF_B  = field_off(F_B,  DEF_B, DEF_H, DEF_P, DEF_N);
  localparam int OFF_C  = field_off(F_C,  DEF_B, DEF_H, DEF_P, DEF_N);
  localparam int OFF_D  = field_off(F_D,  DEF_B, DEF_H, DEF_P, DEF_N);
  localparam int OFF_X  = field_off(F_X,  DEF_B, DEF_H, DEF_P, DEF_N);
  localparam int OFF_H  = field_off(F_H,  DEF_B, DEF_H, DEF_P, DEF_N);

endpackage

// File: rtl/ssm_y_serializer.sv
// ssm_y_serializer: captures the core result vector in one cycle and
// drains it word by word over a valid/ready stream. out_data/out_last
// are registers, so they hold steady while the sink stalls.
module ssm_y_serializer #(
  parameter int DW    = 16,
  parameter int W_OUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  capture,
  input  logic [W_OUT*DW-1:0]   y_in,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  drain_done
);

  localparam int RCNT_W = (W_OUT > 1) ? $clog2(W_OUT) : 1;
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(W_OUT - 1);

  logic [DW-1:0]     y_mem [W_OUT];
  logic [RCNT_W-1:0] rcnt;
  logic [RCNT_W-1:0] rcnt_inc;
  logic              beat;

  assign beat       = out_valid && out_ready;
  assign rcnt_inc   = rcnt + RCNT_W'(1);
  assign drain_done = beat && out_last;

  // Snapshot the whole result vector when the core reports done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < W_OUT; k++) y_mem[k] <= '0;
    end else if (capture) begin
      for (int k = 0; k < W_OUT; k++) y_mem[k] <= y_in[k*DW +: DW];
    end
  end

  // Walk the read counter and present the next word after each accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (capture) begin
      rcnt      <= '0;
      out_valid <= 1'b1;
      out_last  <= (W_OUT == 1);
      out_data  <= y_in[DW-1:0];
    end else if (beat) begin
      if (out_last) begin
        rcnt      <= '0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        rcnt     <= rcnt_inc;
        out_data <= y_mem[rcnt_inc];
        out_last <= (rcnt_inc == RCNT_LAST);
      end
    end
  end

endmodule

// File: rtl/ssm_io_sequencer.sv
// ssm_io_sequencer: loads one token's operands from a word stream into
// registered flat buses, fires the SSM core, waits for done and streams
// the result back out. Optional feature macro SSM_SEQ_PERF_CNT_EN adds a
// core_cycles latency counter port.
module ssm_io_sequencer
  import ssm_pkg::*;
#(
  parameter int B  = 1,
  parameter int H  = 4,
  parameter int P  = 4,
  parameter int N  = 4,
  parameter int DW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DW-1:0]           in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [B*H*DW-1:0]       dt_flat,
  output logic [B*H*DW-1:0]       dA_flat,
  output logic [B*N*DW-1:0]       Bmat_flat,
  output logic [B*N*DW-1:0]       C_flat,
  output logic [H*DW-1:0]         D_flat,
  output logic [B*H*P*DW-1:0]     x_flat,
  output logic [B*H*P*N*DW-1:0]   h_prev_flat,
  output logic                    core_start,
  input  logic                    core_done,
  input  logic [B*H*P*DW-1:0]     core_y_flat,
  output logic [DW-1:0]           out_data,
  output logic                    out_valid,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    frame_err
`ifdef SSM_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]             core_cycles
`endif
);

  localparam int W_IN_C  = w_in(B, H, P, N);
  localparam int W_OUT_C = w_out(B, H, P);
  localparam int WCNT_W  = (W_IN_C > 1) ? $clog2(W_IN_C) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(W_IN_C - 1);

  localparam int O_DT = field_off(F_DT, B, H, P, N);
  localparam int O_DA = field_off(F_DA, B, H, P, N);
  localparam int O_B  = field_off(F_B,  B, H, P, N);
  localparam int O_C  = field_off(F_C,  B, H, P, N);
  localparam int O_D  = field_off(F_D,  B, H, P, N);
  localparam int O_X  = field_off(F_X,  B, H, P, N);
  localparam int O_H  = field_off(F_H,  B, H, P, N);

  seq_state_t             state;
  seq_state_t             next_state;
  logic [WCNT_W-1:0]      wcnt;
  logic [DW-1:0]          op_mem [W_IN_C];
  logic [W_IN_C*DW-1:0]   op_flat;
  logic                   load_accept;
  logic                   last_word;
  logic                   capture;
  logic                   drain_done;

  assign last_word = (wcnt == WCNT_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RST_IDLE;
    else     state <= next_state;
  end

  // Next-state and per-cycle strobes.
  always_comb begin
    next_state  = state;
    load_accept = 1'b0;
    capture     = 1'b0;
    case (state)
      RST_IDLE: next_state = LOAD;
      LOAD: begin
        load_accept = in_valid && in_ready;
        if (load_accept && last_word) next_state = FIRE;
        else                          next_state = LOAD;
      end
      FIRE: next_state = WAIT;
      WAIT: begin
        if (core_done) begin
          capture    = 1'b1;
          next_state = DRAIN;
        end else begin
          next_state = WAIT;
        end
      end
      DRAIN: begin
        if (drain_done) next_state = LOAD;
        else            next_state = DRAIN;
      end
      default: next_state = RST_IDLE;
    endcase
  end

  // Registered handshake/strobe outputs decoded from the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready   <= 1'b0;
      core_start <= 1'b0;
    end else begin
      in_ready   <= (next_state == LOAD);
      core_start <= (next_state == FIRE);
    end
  end

  // Input word counter; framing is purely by count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt <= '0;
    end else if (load_accept) begin
      wcnt <= last_word ? '0 : wcnt + WCNT_W'(1);
    end
  end

  // Operand storage: written only on accepts, frozen from FIRE through DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < W_IN_C; k++) op_mem[k] <= '0;
    end else if (load_accept) begin
      op_mem[wcnt] <= in_data;
    end
  end

  // Sticky flag when in_last disagrees with the word position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
    end else if (load_accept && (in_last != last_word)) begin
      frame_err <= 1'b1;
    end
  end

  // Flatten stored words in frame order so each field is a plain slice.
  always_comb begin
    op_flat = '0;
    for (int k = 0; k < W_IN_C; k++) op_flat[k*DW +: DW] = op_mem[k];
  end

  assign dt_flat     = op_flat[O_DT*DW +: B*H*DW];
  assign dA_flat     = op_flat[O_DA*DW +: B*H*DW];
  assign Bmat_flat   = op_flat[O_B*DW  +: B*N*DW];
  assign C_flat      = op_flat[O_C*DW  +: B*N*DW];
  assign D_flat      = op_flat[O_D*DW  +: H*DW];
  assign x_flat      = op_flat[O_X*DW  +: B*H*P*DW];
  assign h_prev_flat = op_flat[O_H*DW  +: B*H*P*N*DW];

  ssm_y_serializer #(
    .DW    (DW),
    .W_OUT (W_OUT_C)
  ) u_y_ser (
    .clk        (clk),
    .rst        (rst),
    .capture    (capture),
    .y_in       (core_y_flat),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .drain_done (drain_done)
  );

`ifdef SSM_SEQ_PERF_CNT_EN
  // Core latency: cleared in FIRE, counts every WAIT cycle (done cycle included), saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_cycles <= 32'd0;
    end else if (state == FIRE) begin
      core_cycles <= 32'd0;
    end else if ((state == WAIT) && (core_cycles != 32'hFFFF_FFFF)) begin
      core_cycles <= core_cycles + 32'd1;
    end
  end
`endif

endmodule
